spi_master_multi: RTL and testbench
===================================

# spi_master_multi

Parametrised SPI master replacing the fixed 8-bit, 4-slave link. It serialises one `DATA_W`-bit word per transfer to one of `NUM_SLAVES` slaves and captures the word returned on `miso`. It supports all four CPOL/CPHA modes and a programmable SCLK divider, and uses a start/busy/done handshake toward the host logic. It sits between the system-side controller and the physical SPI pins.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer, ≥2.
- `NUM_SLAVES`, default 4: chip selects, ≥1.
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period, ≥1.
- `SEL_W`, default `$clog2(NUM_SLAVES)` (minimum 1): width of the slave index.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: transfer request; sampled only in IDLE.
- `slave_sel` in `SEL_W`: binary slave index; latched at start.
- `cpol` in 1: clock polarity; latched at start.
- `cpha` in 1: clock phase; latched at start.
- `tx_data` in `DATA_W`: word to send, MSB first; latched at start.
- `rx_data` out `DATA_W`: last received word; updated only when `done` is high.
- `busy` out 1: high from start acceptance until `done`.
- `done` out 1: one-cycle pulse at end of transfer.
- `sclk` out 1: serial clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in; the bench keeps it synchronous to `clk`.
- `cs_n` out `NUM_SLAVES`: active-low chip selects; at most one is low.

## Operation
- States:
  - IDLE: `start=1` and `slave_sel<NUM_SLAVES` go to LEAD and latch `slave_sel`, `cpol`, `cpha`, `tx_data`.
  - LEAD: lasts `CLK_DIV` cycles, then XFER.
  - XFER: lasts `2*DATA_W*CLK_DIV` cycles, then TRAIL.
  - TRAIL: lasts `CLK_DIV` cycles, then IDLE with `done` pulsed.
- Chip select: `cs_n[sel]` is low in LEAD, XFER and TRAIL. All other bits stay high.
- SCLK: idles at the latched `cpol`; in IDLE it follows `cpol` with a one-cycle register delay. In XFER it toggles every `CLK_DIV` cycles, giving exactly `2*DATA_W` edges. Odd-numbered edges are leading; even-numbered edges are trailing.
- CPHA=0:
  - MSB is on `mosi` on LEAD entry.
  - `miso` is sampled on leading edges.
  - `mosi` shifts on trailing edges, except the last trailing edge.
- CPHA=1:
  - `mosi` shifts out on leading edges; the first leading edge presents the MSB.
  - `miso` is sampled on trailing edges.
- Shift register: a single `DATA_W`-bit register. It shifts left, and the sampled `miso` bit enters the LSB. `rx_data` loads from it when `done` is asserted.
- `mosi` holds its last bit through TRAIL and returns to 0 in IDLE.
- Ignored requests:
  - `start` while `busy`: no effect.
  - `start` with `slave_sel≥NUM_SLAVES`: no `cs_n` change, `busy` stays 0, no `done`.
- Mode inputs changing mid-transfer have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `cs_n`=all ones, `sclk`=0, `mosi`=0, `rx_data`=0, state IDLE.
- Reset mid-transfer forces the reset values immediately; no `done` is produced.
- Start acceptance: `start` is sampled high at edge k. After edge k, `busy`=1 and `cs_n[sel]`=0.
- Completion: after edge k+(2*DATA_W+2)*CLK_DIV:
  - `done`=1 for one cycle;
  - `busy`=0;
  - `cs_n` all high;
  - `rx_data` valid.
- Back-to-back: `start` may be high in the same cycle `done` is high and is accepted at the next edge. The minimum gap of one IDLE cycle gives CS deassertion of ≥1 `clk`.
- Defaults (`DATA_W`=8, `CLK_DIV`=2): start-to-done is 36 cycles; the SCLK period is 4 `clk` cycles.

## Structure
- Package `spi_pkg`: state enum (IDLE, LEAD, XFER, TRAIL), SPI mode encoding `{cpol,cpha}`, helper for `SEL_W`.
- Sub-module `spi_clk_gen`: half-period counter. It emits one-cycle `lead_edge` and `trail_edge` strobes and drives `sclk` from the latched `cpol`. It is enabled only in XFER.
- Top-level contents: FSM, edge/bit counter (counts to `2*DATA_W`), shift register, CS decoder.

## Test plan
- Mode 0, `slave_sel`=1, `tx_data`=8'hF0, loopback slave returns 8'h0F: slave sees 8'hF0, `rx_data`=8'h0F, `done` 36 cycles after start, only `cs_n[1]` low.
- All four modes, `slave_sel`=3, tx 8'hA5, slave returns 8'h3C: correct data each mode, and `sclk` idles at `cpol` before and after.
- Assert `start` while `busy`, with `slave_sel`=7 on a 4-slave instance: no second transfer, no CS change, exactly one `done`.
- `DATA_W`=16, `CLK_DIV`=3, tx 16'h8001, returns 16'hFFFE: `rx_data`=16'hFFFE, `done` after 102 cycles.
- Back-to-back: start held high through `done`. Second transfer begins next cycle, `cs_n` high for ≥1 cycle between transfers.
- Drop `rst_n` at edge 5 of a transfer: outputs at reset values immediately, no `done`, next start works normally.

Source files
------------

// File: rtl/spi_master_multi_pkg.sv
// Shared types for the SPI master: FSM states, SPI mode encoding {cpol,cpha}
// and a width helper that never returns zero.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sel_width(input int num_slaves);
    return min1_clog2(num_slaves);
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Host handshake plus SPI pin bundle for spi_master_multi. The master modport
// is the controller's view; the slave modport is the host/pin-side view.
interface spi_master_multi_if
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
);

  logic                  start;
  logic [SEL_W-1:0]      slave_sel;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_W-1:0]     tx_data;
  logic [DATA_W-1:0]     rx_data;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_SLAVES-1:0] cs_n;

  modport master (
    input  start, slave_sel, cpol, cpha, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, slave_sel, cpol, cpha, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, cs_n
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: toggles sclk every CLK_DIV cycles while enabled
// and flags which toggle is a leading or trailing edge one cycle ahead of it.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic idle_level,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int            CW        = min1_clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] half_cnt;
  logic          tick;

  // Strobes are valid in the cycle whose closing edge toggles sclk.
  assign tick       = en && (half_cnt == HALF_LAST);
  assign lead_edge  = tick && (sclk == idle_level);
  assign trail_edge = tick && (sclk != idle_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sclk     <= idle_level;
    end else if (tick) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: one DATA_W-bit full-duplex word per transfer to one
// of NUM_SLAVES chip selects, all four CPOL/CPHA modes, start/busy/done handshake.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int CLK_DIV    = 2,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input logic                clk,
  input logic                rst_n,
  spi_master_multi_if.master bus
);

  localparam int               CW        = min1_clog2(CLK_DIV);
  localparam int               EW        = min1_clog2(2 * DATA_W);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0]    EDGE_LAST = EW'(2 * DATA_W - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [EW-1:0]         edge_cnt;
  logic [SEL_W-1:0]      sel_q;
  spi_mode_t             mode_q;
  logic [DATA_W-1:0]     shreg;
  logic [DATA_W-1:0]     rx_q;
  logic [NUM_SLAVES-1:0] cs_n_q;
  logic                  rx_bit;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  done_nxt;
  logic                  accept;
  logic                  last_edge;
  logic                  lead_edge;
  logic                  trail_edge;
  logic                  sclk_int;
  logic                  idle_level;
  logic                  cpol_q;
  logic                  cpha_q;

  function automatic logic [NUM_SLAVES-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SLAVES-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel == SEL_W'(i)) cs[i] = 1'b0;
    return cs;
  endfunction

  assign accept     = (state == IDLE) && bus.start && ({1'b0, bus.slave_sel} < SEL_LIMIT);
  assign last_edge  = (edge_cnt == EDGE_LAST);
  assign cpol_q     = (mode_q == MODE2) || (mode_q == MODE3);
  assign cpha_q     = (mode_q == MODE1) || (mode_q == MODE3);
  // Before a transfer sclk tracks the live cpol input; once latched it is frozen.
  assign idle_level = (state == IDLE) ? bus.cpol : cpol_q;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == XFER),
    .idle_level (idle_level),
    .sclk       (sclk_int),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = LEAD;
      LEAD:  if (cnt == CNT_LAST) state_nxt = XFER;
      XFER:  if (trail_edge && last_edge) state_nxt = TRAIL;
      TRAIL: if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      sel_q    <= '0;
      mode_q   <= MODE0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= '1;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      busy_q <= (state_nxt != IDLE);
      if ((state_nxt != state) || (state == IDLE) || (state == XFER))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state != XFER)
        edge_cnt <= '0;
      else if (lead_edge || trail_edge)
        edge_cnt <= edge_cnt + 1'b1;
      if (accept) begin
        sel_q  <= bus.slave_sel;
        mode_q <= spi_mode_t'({bus.cpol, bus.cpha});
        cs_n_q <= cs_decode(bus.slave_sel);
      end else if (state_nxt == IDLE) begin
        cs_n_q <= '1;
      end
    end
  end

  // CPHA=0 shifts mosi on trailing edges (never the last); CPHA=1 on leading edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= 1'b0;
      rx_q   <= '0;
    end else begin
      if (done_nxt) rx_q <= shreg;
      if (accept)
        mosi_q <= bus.cpha ? 1'b0 : bus.tx_data[DATA_W-1];
      else if (state_nxt == IDLE)
        mosi_q <= 1'b0;
      else if (lead_edge && cpha_q)
        mosi_q <= shreg[DATA_W-1];
      else if (trail_edge && !cpha_q && !last_edge)
        mosi_q <= shreg[DATA_W-2];
    end
  end

  // Single shift register: the miso bit taken on the sampling edge enters the
  // LSB on each trailing edge (held in rx_bit for CPHA=0).
  always_ff @(posedge clk) begin
    if (accept)
      shreg <= bus.tx_data;
    else if (trail_edge)
      shreg <= {shreg[DATA_W-2:0], cpha_q ? bus.miso : rx_bit};
    if (lead_edge) rx_bit <= bus.miso;
  end

  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_int;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: an 8-bit/4-slave instance and a 16-bit/CLK_DIV=3
// instance, each talking to a behavioural SPI slave driven on the falling clk edge.
module tb_spi_master_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_W(8),  .NUM_SLAVES(4), .SEL_W(3)) bus8  ();
  spi_master_multi_if #(.DATA_W(16), .NUM_SLAVES(2), .SEL_W(1)) bus16 ();

  spi_master_multi #(.DATA_W(8), .NUM_SLAVES(4), .CLK_DIV(2), .SEL_W(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  spi_master_multi #(.DATA_W(16), .NUM_SLAVES(2), .CLK_DIV(3), .SEL_W(1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 8-bit slave model
  logic [7:0] s8_word      = '0;
  logic [7:0] s8_rx        = '0;
  logic [1:0] s8_sel       = '0;
  logic       s8_cpol      = 1'b0;
  logic       s8_cpha      = 1'b0;
  logic       s8_prev_cs   = 1'b1;
  logic       s8_prev_sclk = 1'b0;
  int         s8_idx       = 0;
  int         done8_cnt    = 0;

  always @(negedge clk) begin
    if (bus8.done === 1'b1) done8_cnt <= done8_cnt + 1;
    if (!rst_n) begin
      bus8.miso    <= 1'b0;
      s8_idx       <= 0;
      s8_prev_cs   <= 1'b1;
      s8_prev_sclk <= bus8.sclk;
    end else begin
      s8_prev_cs   <= bus8.cs_n[s8_sel];
      s8_prev_sclk <= bus8.sclk;
      if (s8_prev_cs && !bus8.cs_n[s8_sel]) begin
        s8_rx <= '0;
        if (s8_cpha) s8_idx <= 0;
        else begin
          bus8.miso <= s8_word[7];
          s8_idx    <= 1;
        end
      end else if (!bus8.cs_n[s8_sel] && (bus8.sclk != s8_prev_sclk)) begin
        if ((bus8.sclk != s8_cpol) != s8_cpha)
          s8_rx <= {s8_rx[6:0], bus8.mosi};
        else if (s8_idx < 8) begin
          bus8.miso <= s8_word[7 - s8_idx];
          s8_idx    <= s8_idx + 1;
        end
      end
    end
  end

  // 16-bit slave model, mode 0, chip select 1
  logic [15:0] s16_word      = '0;
  logic [15:0] s16_rx        = '0;
  logic        s16_prev_cs   = 1'b1;
  logic        s16_prev_sclk = 1'b0;
  int          s16_idx       = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus16.miso    <= 1'b0;
      s16_idx       <= 0;
      s16_prev_cs   <= 1'b1;
      s16_prev_sclk <= bus16.sclk;
    end else begin
      s16_prev_cs   <= bus16.cs_n[1];
      s16_prev_sclk <= bus16.sclk;
      if (s16_prev_cs && !bus16.cs_n[1]) begin
        s16_rx     <= '0;
        bus16.miso <= s16_word[15];
        s16_idx    <= 1;
      end else if (!bus16.cs_n[1] && (bus16.sclk != s16_prev_sclk)) begin
        if (bus16.sclk)
          s16_rx <= {s16_rx[14:0], bus16.mosi};
        else if (s16_idx < 16) begin
          bus16.miso <= s16_word[15 - s16_idx];
          s16_idx    <= s16_idx + 1;
        end
      end
    end
  end

  task automatic wait_done(input bit use16, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(use16 ? bus16.done : bus8.done) && cyc < 400);
  endtask

  task automatic start8(input logic [2:0] sel, input logic [7:0] tx);
    @(negedge clk);
    bus8.slave_sel = sel;
    bus8.tx_data   = tx;
    bus8.start     = 1'b1;
    @(negedge clk);
    bus8.start     = 1'b0;
  endtask

  task automatic set_mode8(input logic cpol, input logic cpha, input logic [1:0] sel,
                           input logic [7:0] word);
    bus8.cpol = cpol;
    bus8.cpha = cpha;
    s8_cpol   = cpol;
    s8_cpha   = cpha;
    s8_sel    = sel;
    s8_word   = word;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] sword;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;
    int d0;
    int cs_bad;

    vecs[0] = '{3'd1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h0F, 4'b1101};
    vecs[1] = '{3'd3, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 4'b0111};
    vecs[2] = '{3'd3, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 4'b0111};
    vecs[3] = '{3'd3, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h3C, 4'b0111};
    vecs[4] = '{3'd3, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h3C, 4'b0111};

    bus8.start  = 1'b0; bus8.slave_sel  = '0; bus8.cpol  = 1'b0; bus8.cpha  = 1'b0; bus8.tx_data  = '0;
    bus16.start = 1'b0; bus16.slave_sel = '0; bus16.cpol = 1'b0; bus16.cpha = 1'b0; bus16.tx_data = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  bus8.busy,    1'b0);
    check("rst_done",  bus8.done,    1'b0);
    check("rst_cs_n",  bus8.cs_n,    4'hF);
    check("rst_sclk",  bus8.sclk,    1'b0);
    check("rst_mosi",  bus8.mosi,    1'b0);
    check("rst_rx",    bus8.rx_data, 8'h00);
    check("rst16_cs_n", bus16.cs_n,  2'b11);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      set_mode8(vecs[i].cpol, vecs[i].cpha, vecs[i].sel[1:0], vecs[i].sword);
      check($sformatf("v%0d_sclk_idle_pre", i), bus8.sclk, vecs[i].cpol);
      start8(vecs[i].sel, vecs[i].tx);
      check($sformatf("v%0d_busy", i), bus8.busy, 1'b1);
      check($sformatf("v%0d_cs_n", i), bus8.cs_n, vecs[i].exp_cs);
      if (!vecs[i].cpha) check($sformatf("v%0d_mosi_msb", i), bus8.mosi, vecs[i].tx[7]);
      wait_done(1'b0, cyc);
      check($sformatf("v%0d_latency", i), cyc, 36);
      check($sformatf("v%0d_rx_data", i), bus8.rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_slave_rx", i), s8_rx, vecs[i].tx);
      check($sformatf("v%0d_cs_release", i), bus8.cs_n, 4'hF);
      check($sformatf("v%0d_busy_end", i), bus8.busy, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), bus8.done, 1'b0);
      check($sformatf("v%0d_sclk_idle_post", i), bus8.sclk, vecs[i].cpol);
      check($sformatf("v%0d_mosi_idle", i), bus8.mosi, 1'b0);
    end

    // start while busy, with an out-of-range select and changed mode inputs
    set_mode8(1'b0, 1'b0, 2'd2, 8'h99);
    d0 = done8_cnt;
    start8(3'd2, 8'h33);
    repeat (3) @(negedge clk);
    bus8.slave_sel = 3'd7;
    bus8.tx_data   = 8'hFF;
    bus8.cpha      = 1'b1;
    bus8.start     = 1'b1;
    cs_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus8.cs_n !== 4'b1011) cs_bad++;
    end
    bus8.start = 1'b0;
    bus8.cpha  = 1'b0;
    wait_done(1'b0, cyc);
    check("busy_ign_timeout", cyc < 400, 1'b1);
    check("busy_ign_cs", cs_bad, 0);
    check("busy_ign_rx", bus8.rx_data, 8'h99);
    check("busy_ign_slave_rx", s8_rx, 8'h33);
    repeat (40) @(negedge clk);
    check("busy_ign_done_cnt", done8_cnt - d0, 1);

    // out-of-range select from IDLE
    d0 = done8_cnt;
    start8(3'd7, 8'h12);
    check("badsel_busy", bus8.busy, 1'b0);
    check("badsel_cs_n", bus8.cs_n, 4'hF);
    repeat (40) @(negedge clk);
    check("badsel_done_cnt", done8_cnt - d0, 0);

    // 16-bit, CLK_DIV=3
    s16_word = 16'hFFFE;
    @(negedge clk);
    bus16.slave_sel = 1'b1;
    bus16.tx_data   = 16'h8001;
    bus16.start     = 1'b1;
    @(negedge clk);
    bus16.start     = 1'b0;
    check("w16_busy", bus16.busy, 1'b1);
    check("w16_cs_n", bus16.cs_n, 2'b01);
    wait_done(1'b1, cyc);
    check("w16_latency", cyc, 102);
    check("w16_rx_data", bus16.rx_data, 16'hFFFE);
    check("w16_slave_rx", s16_rx, 16'h8001);
    check("w16_cs_release", bus16.cs_n, 2'b11);

    // back-to-back with start held high through done
    set_mode8(1'b0, 1'b0, 2'd0, 8'h81);
    bus8.slave_sel = 3'd0;
    bus8.tx_data   = 8'h7E;
    bus8.start     = 1'b1;
    @(negedge clk);
    wait_done(1'b0, cyc);
    check("b2b_latency1", cyc, 36);
    check("b2b_rx1", bus8.rx_data, 8'h81);
    check("b2b_cs_gap", bus8.cs_n, 4'hF);
    bus8.tx_data = 8'h5A;
    s8_word      = 8'hC3;
    @(negedge clk);
    bus8.start = 1'b0;
    check("b2b_busy2", bus8.busy, 1'b1);
    check("b2b_cs2", bus8.cs_n, 4'b1110);
    wait_done(1'b0, cyc);
    check("b2b_latency2", cyc, 36);
    check("b2b_rx2", bus8.rx_data, 8'hC3);
    check("b2b_slave_rx2", s8_rx, 8'h5A);

    // reset in the middle of a transfer
    set_mode8(1'b0, 1'b0, 2'd1, 8'hAA);
    start8(3'd1, 8'hD5);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus8.busy, 1'b0);
    check("mid_rst_done", bus8.done, 1'b0);
    check("mid_rst_cs_n", bus8.cs_n, 4'hF);
    check("mid_rst_sclk", bus8.sclk, 1'b0);
    check("mid_rst_mosi", bus8.mosi, 1'b0);
    check("mid_rst_rx", bus8.rx_data, 8'h00);
    check("mid_rst_rx16", bus16.rx_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done8_cnt;
    repeat (60) @(negedge clk);
    check("mid_rst_no_done", done8_cnt - d0, 0);
    set_mode8(1'b0, 1'b0, 2'd1, 8'h69);
    start8(3'd1, 8'h96);
    check("post_rst_cs_n", bus8.cs_n, 4'b1101);
    wait_done(1'b0, cyc);
    check("post_rst_latency", cyc, 36);
    check("post_rst_rx", bus8.rx_data, 8'h69);
    check("post_rst_slave_rx", s8_rx, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
